// File: rtl/gxsim_smem_arbiter_if.sv
// Bus bundle for the SMEM arbiter: QSPI requester, background requester
// and the single-bank SMEM port. The arbiter uses the slave modport; the
// surrounding system (requesters plus SMEM) uses the master modport.
//
// Handshake semantics:
//   qspi_req is a one-cycle strobe sampled together with qspi_rw, qspi_addr
//   and qspi_wdata; qspi_busy rises the cycle after an accepted strobe and
//   falls in the cycle qspi_done pulses. A strobe seen while qspi_busy=1 is
//   dropped and flagged on the sticky qspi_overrun.
//   bg_req is a level request; bg_rw/bg_addr/bg_wdata stay stable until
//   bg_done pulses for one cycle, with bg_rdata valid in that same cycle.
//   smem_rdata is valid one cycle after a cycle with smem_en=1, smem_we=0.
interface gxsim_smem_arbiter_if #(
  parameter int SMEM_BW = 512,
  parameter int SMEM_AW = 14
) ();
  logic               qspi_req;
  logic               qspi_rw;
  logic [31:0]        qspi_addr;
  logic [31:0]        qspi_wdata;
  logic [SMEM_BW-1:0] qspi_rdata;
  logic               qspi_done;
  logic               qspi_busy;
  logic               qspi_overrun;
  logic               qspi_err_clr;
  logic               bg_req;
  logic               bg_rw;
  logic [SMEM_AW-1:0] bg_addr;
  logic [31:0]        bg_wdata;
  logic [31:0]        bg_rdata;
  logic               bg_done;
  logic               smem_en;
  logic               smem_we;
  logic [SMEM_AW-1:0] smem_addr;
  logic [31:0]        smem_wdata;
  logic [31:0]        smem_rdata;

  modport slave (
    input  qspi_req, qspi_rw, qspi_addr, qspi_wdata, qspi_err_clr,
    output qspi_rdata, qspi_done, qspi_busy, qspi_overrun,
    input  bg_req, bg_rw, bg_addr, bg_wdata,
    output bg_rdata, bg_done,
    output smem_en, smem_we, smem_addr, smem_wdata,
    input  smem_rdata
  );

  modport master (
    output qspi_req, qspi_rw, qspi_addr, qspi_wdata, qspi_err_clr,
    input  qspi_rdata, qspi_done, qspi_busy, qspi_overrun,
    output bg_req, bg_rw, bg_addr, bg_wdata,
    input  bg_rdata, bg_done,
    input  smem_en, smem_we, smem_addr, smem_wdata,
    output smem_rdata
  );
endinterface

// File: rtl/gxsim_smem_arbiter.sv
// Two-requester arbiter for one bank's 32-bit SMEM port. The QSPI path gets
// strict priority and issues SMEM_BW-wide burst reads (one SMEM word per
// cycle) or single-word writes; the background copy engine issues
// single-word accesses. Every operation returns through IDLE for one cycle.
module gxsim_smem_arbiter #(
  parameter int SMEM_BW = 512,
  parameter int SMEM_AW = 14
) (
  input  logic                 clk,
  input  logic                 resetn,
  gxsim_smem_arbiter_if.slave  bus,
  output logic [2:0]           dbg_state
);

  localparam int SMEM_DW = SMEM_BW / 32;
  localparam int CW      = $clog2(SMEM_DW);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    Q_RD     = 3'd1,
    Q_RDLAST = 3'd2,
    Q_WR     = 3'd3,
    BG_RD    = 3'd4,
    BG_RDW   = 3'd5,
    BG_WR    = 3'd6
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic                busy;
  logic                pend_rw;
  logic [SMEM_AW-1:0]  pend_addr;
  logic [31:0]         pend_wdata;
  logic [CW-1:0]       cnt;
  logic [SMEM_BW-33:0] asm_q;
  logic [SMEM_BW-1:0]  asm_shift;
  logic                accept;
  logic                drop;
  logic                q_fin;
  logic                bg_fin;
  logic                unused_addr_hi;

  // Only the low SMEM_AW bits of the QSPI word address select SMEM.
  assign unused_addr_hi = ^bus.qspi_addr[31:SMEM_AW];

  assign accept    = bus.qspi_req && !busy;
  assign drop      = bus.qspi_req && busy;
  assign q_fin     = (state == Q_RDLAST) || (state == Q_WR);
  assign bg_fin    = (state == BG_RDW) || (state == BG_WR);
  assign asm_shift = {asm_q, bus.smem_rdata};
  assign bus.qspi_busy = busy;
  assign dbg_state     = state;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // QSPI pending latch, busy flag and sticky overrun (a drop beats a clear).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy             <= 1'b0;
      pend_rw          <= 1'b0;
      pend_addr        <= '0;
      pend_wdata       <= '0;
      bus.qspi_overrun <= 1'b0;
    end else begin
      if (accept) begin
        busy       <= 1'b1;
        pend_rw    <= bus.qspi_rw;
        pend_addr  <= bus.qspi_addr[SMEM_AW-1:0];
        pend_wdata <= bus.qspi_wdata;
      end else if (q_fin) begin
        busy <= 1'b0;
      end
      if (drop)                  bus.qspi_overrun <= 1'b1;
      else if (bus.qspi_err_clr) bus.qspi_overrun <= 1'b0;
    end
  end

  // Burst word counter and internal assembly buffer; the visible read word
  // is only replaced as a whole when the last word arrives.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt            <= '0;
      asm_q          <= '0;
      bus.qspi_rdata <= '0;
      bus.qspi_done  <= 1'b0;
    end else begin
      bus.qspi_done <= q_fin;
      if (state == Q_RD) begin
        cnt <= cnt + CW'(1);
        // Data for the read issued in the previous cycle arrives now.
        if (cnt != '0) asm_q <= asm_shift[SMEM_BW-33:0];
      end
      if (state == Q_RDLAST) bus.qspi_rdata <= asm_shift;
    end
  end

  // Background read data capture and completion strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.bg_rdata <= '0;
      bus.bg_done  <= 1'b0;
    end else begin
      bus.bg_done <= bg_fin;
      if (state == BG_RDW) bus.bg_rdata <= bus.smem_rdata;
    end
  end

  // Next-state decode and SMEM port drive.
  always_comb begin
    state_nxt      = state;
    bus.smem_en    = 1'b0;
    bus.smem_we    = 1'b0;
    bus.smem_addr  = '0;
    bus.smem_wdata = '0;
    case (state)
      IDLE: begin
        // A strobe arriving this cycle also blocks a background grant so the
        // QSPI path wins when both requesters ask at once.
        if (busy)                               state_nxt = pend_rw ? Q_WR : Q_RD;
        else if (bus.bg_req && !bus.qspi_req)   state_nxt = bus.bg_rw ? BG_WR : BG_RD;
      end
      Q_RD: begin
        bus.smem_en   = 1'b1;
        bus.smem_addr = {pend_addr[SMEM_AW-1:CW], cnt};
        if (cnt == CW'(SMEM_DW - 1)) state_nxt = Q_RDLAST;
      end
      Q_RDLAST: state_nxt = IDLE;
      Q_WR: begin
        bus.smem_en    = 1'b1;
        bus.smem_we    = 1'b1;
        bus.smem_addr  = pend_addr;
        bus.smem_wdata = pend_wdata;
        state_nxt      = IDLE;
      end
      BG_RD: begin
        bus.smem_en   = 1'b1;
        bus.smem_addr = bus.bg_addr;
        state_nxt     = BG_RDW;
      end
      BG_RDW: state_nxt = IDLE;
      BG_WR: begin
        bus.smem_en    = 1'b1;
        bus.smem_we    = 1'b1;
        bus.smem_addr  = bus.bg_addr;
        bus.smem_wdata = bus.bg_wdata;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
